de2_115_pio_ext: RTL and testbench

DE2_115_PIO_EXT -- requirements
Module: de2_115_pio_ext

---
 rtl/de2_115_pio_pkg.sv | 20 ++
 rtl/de2_115_pio_edge.sv | 38 +++
 rtl/de2_115_pio_ext.sv | 131 +++++++++++++
 tb/tb_de2_115_pio_ext.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/de2_115_pio_pkg.sv
// Shared constants for the extended PIO: register word addresses and blink
// prescaler width.
package de2_115_pio_pkg;

  localparam int BLINK_W = 24;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_INPUT        = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR       = 3'd5;
  localparam logic [2:0] ADDR_BLINK_EN     = 3'd6;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd7;

  function automatic logic [BLINK_W-1:0] period_field(input logic [31:0] wd);
    return wd[BLINK_W-1:0];
  endfunction

endpackage

// File: rtl/de2_115_pio_edge.sv
// Two-flop input synchroniser with a rising-edge pulse per bit; pulses are
// suppressed for the first cycle after reset.
module de2_115_pio_edge
  import de2_115_pio_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] prev_r;
  logic             armed_r;

  // synchroniser chain, previous-sample stage and post-reset arming flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_r  <= '0;
      sync    <= '0;
      prev_r  <= '0;
      armed_r <= 1'b0;
    end else begin
      meta_r  <= in_port;
      sync    <= meta_r;
      prev_r  <= sync;
      armed_r <= 1'b1;
    end
  end

  always_comb begin
    rise = sync & ~prev_r & {WIDTH{armed_r}};
  end

endmodule

// File: rtl/de2_115_pio_ext.sv
// Memory-mapped parallel I/O with set/clear shortcuts, rising-edge capture
// interrupt and a per-bit blink overlay driven by a programmable prescaler.
module de2_115_pio_ext
  import de2_115_pio_pkg::*;
#(
  parameter int                 WIDTH         = 9,
  parameter logic [WIDTH-1:0]   RESET_VALUE   = '0,
  parameter logic [BLINK_W-1:0] BLINK_DEFAULT = 24'd12499999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  logic               wr_s;
  logic               rd_s;
  logic [WIDTH-1:0]   wd_s;
  logic [WIDTH-1:0]   sync_s;
  logic [WIDTH-1:0]   rise_s;
  logic [WIDTH-1:0]   data_nxt_s;
  logic [WIDTH-1:0]   clr_s;
  logic [31:0]        rd_val_s;
  logic               unused_wd_s;

  logic [WIDTH-1:0]   data_r;
  logic [WIDTH-1:0]   irq_mask_r;
  logic [WIDTH-1:0]   edge_cap_r;
  logic [WIDTH-1:0]   blink_en_r;
  logic [BLINK_W-1:0] blink_period_r;
  logic [BLINK_W-1:0] counter_r;
  logic               blink_phase_r;

  assign wr_s        = chipselect & ~write_n;
  assign rd_s        = chipselect & ~read_n;
  assign wd_s        = writedata[WIDTH-1:0];
  assign unused_wd_s = ^writedata;

  de2_115_pio_edge #(.WIDTH(WIDTH)) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync    (sync_s),
    .rise    (rise_s)
  );

  // next data register value and edge-capture clear mask for this access
  always_comb begin
    data_nxt_s = data_r;
    clr_s      = '0;
    if (wr_s) begin
      case (address)
        ADDR_DATA:     data_nxt_s = wd_s;
        ADDR_OUTSET:   data_nxt_s = data_r | wd_s;
        ADDR_OUTCLR:   data_nxt_s = data_r & ~wd_s;
        ADDR_EDGE_CAP: clr_s      = wd_s;
        default:       data_nxt_s = data_r;
      endcase
    end else begin
      data_nxt_s = data_r;
    end
  end

  // read mux sees pre-write state, so a colliding write returns the old value
  always_comb begin
    rd_val_s = 32'd0;
    case (address)
      ADDR_DATA:         rd_val_s[WIDTH-1:0]   = data_r;
      ADDR_INPUT:        rd_val_s[WIDTH-1:0]   = sync_s;
      ADDR_IRQ_MASK:     rd_val_s[WIDTH-1:0]   = irq_mask_r;
      ADDR_EDGE_CAP:     rd_val_s[WIDTH-1:0]   = edge_cap_r;
      ADDR_BLINK_EN:     rd_val_s[WIDTH-1:0]   = blink_en_r;
      ADDR_BLINK_PERIOD: rd_val_s[BLINK_W-1:0] = blink_period_r;
      default:           rd_val_s              = 32'd0;
    endcase
  end

  // bus-visible registers; a new edge wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_r     <= RESET_VALUE;
      irq_mask_r <= '0;
      edge_cap_r <= '0;
      blink_en_r <= '0;
      readdata   <= 32'd0;
    end else begin
      data_r     <= data_nxt_s;
      edge_cap_r <= (edge_cap_r & ~clr_s) | rise_s;
      if (wr_s && address == ADDR_IRQ_MASK) irq_mask_r <= wd_s;
      if (wr_s && address == ADDR_BLINK_EN) blink_en_r <= wd_s;
      if (rd_s) readdata <= rd_val_s;
    end
  end

  // blink prescaler: reload and toggle at zero, restart on a period write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_period_r <= BLINK_DEFAULT;
      counter_r      <= BLINK_DEFAULT;
      blink_phase_r  <= 1'b0;
    end else if (wr_s && address == ADDR_BLINK_PERIOD) begin
      blink_period_r <= period_field(writedata);
      counter_r      <= period_field(writedata);
      blink_phase_r  <= 1'b0;
    end else if (counter_r == {BLINK_W{1'b0}}) begin
      counter_r      <= blink_period_r;
      blink_phase_r  <= ~blink_phase_r;
    end else begin
      counter_r      <= counter_r - 24'd1;
    end
  end

  // registered pin outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
      irq      <= 1'b0;
    end else begin
      out_port <= data_r ^ (blink_en_r & {WIDTH{blink_phase_r}});
      irq      <= |(edge_cap_r & irq_mask_r);
    end
  end

endmodule

// File: tb/tb_de2_115_pio_ext.sv
// Directed self-checking bench for de2_115_pio_ext (WIDTH=9, RESET_VALUE=0A5).
module tb_de2_115_pio_ext;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [8:0]  in_port = 9'd0;
  logic [8:0]  out_port;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] BLINK_DEF = 32'd12499999;

  de2_115_pio_ext #(
    .WIDTH         (9),
    .RESET_VALUE   (9'h0A5),
    .BLINK_DEFAULT (24'd12499999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_port !== 9'h0A5) begin n_err++; $display("FAIL reset_out_port: got %h expected 0a5", out_port); end
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
    reset_n = 1'b1;
    bus_read(3'd7, v);
    n_cmp++; if (v !== BLINK_DEF) begin n_err++; $display("FAIL reset_blink_period: got %0d expected %0d", v, BLINK_DEF); end
    bus_read(3'd0, v);
    n_cmp++; if (v !== 32'h0A5) begin n_err++; $display("FAIL reset_data: got %h expected 0a5", v); end
  endtask

  task automatic test_data();
    logic [31:0] v;
    bus_write(3'd0, 32'h0F0);
    bus_write(3'd4, 32'h003);
    bus_write(3'd5, 32'h010);
    bus_read(3'd0, v);
    n_cmp++; if (v !== 32'h0E3) begin n_err++; $display("FAIL data_setclr: got %h expected 0e3", v); end
    n_cmp++; if (out_port !== 9'h0E3) begin n_err++; $display("FAIL data_out_port: got %h expected 0e3", out_port); end
    bus_read(3'd4, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL read_outset: got %h expected 0", v); end
  endtask

  task automatic test_edge();
    logic [31:0] v;
    bit seen = 1'b0;
    int waited = 0;
    bus_write(3'd2, 32'h004);
    bus_read(3'd2, v);
    n_cmp++; if (v !== 32'h004) begin n_err++; $display("FAIL irq_mask_read: got %h expected 004", v); end
    in_port = 9'h004;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      waited = i + 1;
      if (irq === 1'b1) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!(seen && waited <= 4)) begin n_err++; $display("FAIL edge_irq_latency: got seen=%b after %0d cycles expected irq within 4", seen, waited); end
    bus_read(3'd3, v);
    n_cmp++; if (v !== 32'h004) begin n_err++; $display("FAIL edge_cap: got %h expected 004", v); end
    bus_read(3'd1, v);
    n_cmp++; if (v !== 32'h004) begin n_err++; $display("FAIL input_read: got %h expected 004", v); end
    bus_write(3'd3, 32'h004);
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b expected 0", irq); end
    bus_read(3'd3, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL edge_cap_cleared: got %h expected 0", v); end
  endtask

  task automatic test_simul_clear();
    logic [31:0] v;
    in_port = 9'h000;
    repeat (5) @(posedge clk);
    #1;
    in_port = 9'h004;
    @(posedge clk);
    // clear lands on the same edge that captures the new rising edge
    bus_write(3'd3, 32'h004);
    bus_read(3'd3, v);
    n_cmp++; if (v !== 32'h004) begin n_err++; $display("FAIL edge_vs_clear: got %h expected 004", v); end
    bus_write(3'd2, 32'h000);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_masked: got %b expected 0", irq); end
    bus_write(3'd3, 32'h1FF);
    bus_read(3'd3, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL edge_cap_clear_all: got %h expected 0", v); end
  endtask

  task automatic test_blink();
    logic [31:0] v;
    logic        prev_bit;
    int          last_chg = -1;
    int          toggles = 0;
    bus_write(3'd0, 32'h000);
    bus_write(3'd7, 32'd3);
    bus_write(3'd6, 32'h001);
    bus_read(3'd7, v);
    n_cmp++; if (v !== 32'd3) begin n_err++; $display("FAIL blink_period_read: got %h expected 3", v); end
    bus_read(3'd6, v);
    n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL blink_en_read: got %h expected 1", v); end
    prev_bit = out_port[0];
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_port[8:1] !== 8'd0) begin n_err++; $display("FAIL blink_upper_bits: got %h expected 00", out_port[8:1]); end
      if (out_port[0] !== prev_bit) begin
        if (last_chg >= 0) begin
          n_cmp++; if (i - last_chg !== 4) begin n_err++; $display("FAIL blink_interval: got %0d expected 4", i - last_chg); end
        end
        last_chg = i;
        toggles++;
        prev_bit = out_port[0];
      end
    end
    n_cmp++; if (toggles < 5) begin n_err++; $display("FAIL blink_toggle_count: got %0d expected at least 5", toggles); end
    bus_write(3'd7, 32'd0);
    prev_bit = out_port[0];
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_port[0] === prev_bit) begin n_err++; $display("FAIL blink_period0: got %b expected %b", out_port[0], ~prev_bit); end
      prev_bit = out_port[0];
    end
    bus_write(3'd6, 32'h000);
  endtask

  task automatic test_collision();
    logic [31:0] v;
    bus_write(3'd0, 32'h03C);
    bus_read(3'd0, v);
    n_cmp++; if (v !== 32'h03C) begin n_err++; $display("FAIL data_read: got %h expected 03c", v); end
    bus_read(3'd5, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL read_outclr: got %h expected 0", v); end
    bus_read(3'd0, v);
    @(posedge clk); #1;
    address = 3'd0; writedata = 32'h155; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    n_cmp++; if (readdata !== 32'h03C) begin n_err++; $display("FAIL rw_collision: got %h expected 03c", readdata); end
    bus_read(3'd0, v);
    n_cmp++; if (v !== 32'h155) begin n_err++; $display("FAIL data_after_write: got %h expected 155", v); end
    n_cmp++; if (out_port !== 9'h155) begin n_err++; $display("FAIL out_port_no_blink: got %h expected 155", out_port); end
  endtask

  task automatic test_reset_override();
    logic [31:0] v;
    @(posedge clk); #1;
    address = 3'd0; writedata = 32'h1FF; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    reset_n = 1'b1;
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL rst_override_readdata: got %h expected 0", readdata); end
    n_cmp++; if (out_port !== 9'h0A5) begin n_err++; $display("FAIL rst_override_out_port: got %h expected 0a5", out_port); end
    bus_read(3'd0, v);
    n_cmp++; if (v !== 32'h0A5) begin n_err++; $display("FAIL rst_override_data: got %h expected 0a5", v); end
    bus_read(3'd7, v);
    n_cmp++; if (v !== BLINK_DEF) begin n_err++; $display("FAIL rst_override_period: got %0d expected %0d", v, BLINK_DEF); end
  endtask

  initial begin
    test_reset();
    test_data();
    test_edge();
    test_simul_clear();
    test_blink();
    test_collision();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
